// File: rtl/freq_gate_scheduler.sv
// freq_gate_scheduler: gated edge counter with sequential double-dabble BCD result.
// Define FREQ_GATE_OVF_BLANK_EN to show a saturated result as all-4'hF digits.
module freq_gate_scheduler #(
  parameter int GATE_CYCLES = 250,
  parameter int CNT_W       = 8,
  parameter int NDIG        = 3,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic              sig_edge,
  output logic              gate_open,
  output logic              busy,
  output logic              result_valid,
  output logic              ovf_o,
  output logic [4*NDIG-1:0] bcd_o
);
  localparam int MX = (GATE_CYCLES > CNT_W) ? ((GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES)
                                            : ((CNT_W > HOLD_CYCLES) ? CNT_W : HOLD_CYCLES);
  localparam int TW = $clog2(MX + 1);
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};
`ifdef FREQ_GATE_OVF_BLANK_EN
  localparam logic BLANK = 1'b1;
`else
  localparam logic BLANK = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, ARM, GATE, LATCH, CONV, SHOW} state_t;
  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [CNT_W-1:0]  edge_q, edge_d, bin_q, bin_d;
  logic              sat_q, sat_d, ovf_q, ovf_d, gate_q, busy_q, rv_q;
  logic [4*NDIG-1:0] acc_q, acc_d, bcd_q, bcd_d, adj, shifted;
  logic              gate_last, conv_last, hold_last;
  for (genvar i = 0; i < NDIG; i++) begin : g_adj
    assign adj[4*i+:4] = (acc_q[4*i+:4] >= 4'd5) ? acc_q[4*i+:4] + 4'd3 : acc_q[4*i+:4];
  end
  assign shifted   = (adj << 1) | (4*NDIG)'(bin_q[CNT_W-1]);
  assign gate_last = tmr_q == TW'(GATE_CYCLES - 1);
  assign conv_last = tmr_q == TW'(CNT_W - 1);
  assign hold_last = tmr_q == TW'(HOLD_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    edge_d  = edge_q;
    sat_d   = sat_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: state_d = run ? ARM : IDLE;
      ARM: begin
        tmr_d   = '0;
        edge_d  = '0;
        sat_d   = 1'b0;
        state_d = run ? GATE : IDLE;
      end
      GATE: begin
        if (!run) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else begin
          edge_d  = (sig_edge && edge_q != CMAX) ? edge_q + 1'b1 : edge_q;
          sat_d   = sat_q | (edge_d == CMAX);
          tmr_d   = gate_last ? '0 : tmr_q + 1'b1;
          state_d = gate_last ? LATCH : GATE;
        end
      end
      LATCH: begin
        bin_d   = edge_q;
        acc_d   = '0;
        tmr_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        bin_d   = bin_q << 1;
        acc_d   = shifted;
        tmr_d   = conv_last ? '0 : tmr_q + 1'b1;
        state_d = conv_last ? SHOW : CONV;
        bcd_d   = conv_last ? ((BLANK && sat_q) ? '1 : shifted) : bcd_q;
        ovf_d   = conv_last ? sat_q : ovf_q;
      end
      SHOW: begin
        tmr_d   = hold_last ? '0 : tmr_q + 1'b1;
        state_d = hold_last ? (run ? ARM : IDLE) : SHOW;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      edge_q  <= '0;
      sat_q   <= 1'b0;
      bin_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      gate_q  <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      edge_q  <= edge_d;
      sat_q   <= sat_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      gate_q  <= state_d == GATE;
      busy_q  <= state_d != IDLE;
      rv_q    <= state_q == CONV && conv_last;
    end
  end
  assign gate_open    = gate_q;
  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign ovf_o        = ovf_q;
  assign bcd_o        = bcd_q;
endmodule

// File: tb/tb_freq_gate_scheduler.sv
// tb_freq_gate_scheduler: directed checks of gate timing, abort, saturation and async reset.
module tb_freq_gate_scheduler;
  logic clk = 0, reset_n = 0, run = 0, sig_edge = 0, run2 = 0, edge2 = 0;
  logic gate_open, busy, result_valid, ovf_o, gate2, busy2, rv2, ovf2;
  logic [11:0] bcd_o, bcd2;
  int vec = 0, errs = 0;
`ifdef FREQ_GATE_OVF_BLANK_EN
  localparam logic [11:0] SAT_BCD = 12'hFFF;
`else
  localparam logic [11:0] SAT_BCD = 12'h255;
`endif
  always #5 clk = ~clk;
  freq_gate_scheduler #(.GATE_CYCLES(20), .CNT_W(8), .NDIG(3), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .sig_edge(sig_edge), .gate_open(gate_open),
    .busy(busy), .result_valid(result_valid), .ovf_o(ovf_o), .bcd_o(bcd_o));
  freq_gate_scheduler #(.GATE_CYCLES(300), .CNT_W(8), .NDIG(3), .HOLD_CYCLES(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .run(run2), .sig_edge(edge2), .gate_open(gate2),
    .busy(busy2), .result_valid(rv2), .ovf_o(ovf2), .bcd_o(bcd2));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset_n = 0;
    repeat (2) step();
    vec++; if ({gate_open, busy, result_valid, ovf_o, bcd_o} !== 16'h0) begin errs++; $display("FAIL reset_d1 got %h want 0000", {gate_open, busy, result_valid, ovf_o, bcd_o}); end
    vec++; if ({gate2, busy2, rv2, ovf2, bcd2} !== 16'h0) begin errs++; $display("FAIL reset_d2 got %h want 0000", {gate2, busy2, rv2, ovf2, bcd2}); end
    reset_n = 1;
    step();
    vec++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_after_reset busy got %b want 0", busy); end
  endtask
  task automatic test_basic();
    int rv_at = -1, gates = 0, first_gate = -1;
    logic [11:0] got = 'x;
    logic got_ovf = 'x;
    run = 1;
    step();
    vec++; if ({busy, gate_open} !== 2'b10) begin errs++; $display("FAIL arm_flags got %b want 10", {busy, gate_open}); end
    for (int c = 0; c < 40; c++) begin
      if (gate_open) begin gates++; if (first_gate < 0) first_gate = c; end
      if (result_valid) begin rv_at = c; got = bcd_o; got_ovf = ovf_o; break; end
      sig_edge = (c >= 1 && c <= 20 && c % 4 == 0);
      step();
    end
    sig_edge = 0;
    vec++; if (gates != 20) begin errs++; $display("FAIL gate_len got %0d want 20", gates); end
    vec++; if (first_gate != 1) begin errs++; $display("FAIL gate_start got %0d want 1", first_gate); end
    vec++; if (rv_at != 30) begin errs++; $display("FAIL basic_latency got %0d want 30", rv_at); end
    vec++; if (got !== 12'h005) begin errs++; $display("FAIL basic_bcd got %h want 005", got); end
    vec++; if (got_ovf !== 1'b0) begin errs++; $display("FAIL basic_ovf got %b want 0", got_ovf); end
    step();
    vec++; if (result_valid !== 1'b0) begin errs++; $display("FAIL rv_pulse_width got %b want 0", result_valid); end
  endtask
  task automatic test_abort();
    int n = 0, rvn = 0;
    while (!gate_open && n < 20) begin step(); n++; end
    repeat (9) step();
    run = 0;
    step();
    vec++; if ({busy, gate_open, result_valid} !== 3'b000) begin errs++; $display("FAIL abort_idle got %b want 000", {busy, gate_open, result_valid}); end
    for (int c = 0; c < 40; c++) begin
      if (result_valid) rvn++;
      step();
    end
    vec++; if (rvn != 0) begin errs++; $display("FAIL abort_no_rv got %0d want 0", rvn); end
    vec++; if ({ovf_o, bcd_o} !== 13'h0005) begin errs++; $display("FAIL abort_keep got %h want 0005", {ovf_o, bcd_o}); end
  endtask
  task automatic test_conv_drop();
    int rvn = 0, rv_at = -1;
    logic b33 = 'x, b34 = 'x;
    logic [11:0] got = 'x;
    run = 1;
    step();
    for (int c = 0; c < 40; c++) begin
      if (result_valid) begin rvn++; rv_at = c; got = bcd_o; end
      if (c == 33) b33 = busy;
      if (c == 34) b34 = busy;
      sig_edge = (c >= 1 && c <= 7);
      if (c == 23) run = 0;
      step();
    end
    sig_edge = 0;
    vec++; if (rvn != 1) begin errs++; $display("FAIL conv_drop_rv_count got %0d want 1", rvn); end
    vec++; if (rv_at != 30) begin errs++; $display("FAIL conv_drop_latency got %0d want 30", rv_at); end
    vec++; if (got !== 12'h007) begin errs++; $display("FAIL conv_drop_bcd got %h want 007", got); end
    vec++; if ({b33, b34} !== 2'b10) begin errs++; $display("FAIL conv_drop_show_len got %b want 10", {b33, b34}); end
  endtask
  task automatic test_back_to_back();
    int rvn = 0, r0 = -1, r1 = -1;
    run = 1;
    step();
    for (int c = 0; c < 70; c++) begin
      if (result_valid) begin
        rvn++;
        if (r0 < 0) r0 = c; else r1 = c;
        vec++; if ({ovf_o, bcd_o} !== 13'h0) begin errs++; $display("FAIL b2b_bcd got %h want 0000", {ovf_o, bcd_o}); end
      end
      sig_edge = !((c % 34) >= 1 && (c % 34) <= 20);
      step();
    end
    sig_edge = 0;
    vec++; if (rvn != 2) begin errs++; $display("FAIL b2b_count got %0d want 2", rvn); end
    vec++; if (r0 != 30) begin errs++; $display("FAIL b2b_first got %0d want 30", r0); end
    vec++; if (r1 - r0 != 34) begin errs++; $display("FAIL b2b_period got %0d want 34", r1 - r0); end
  endtask
  task automatic test_saturate();
    int rv_at = -1;
    logic [11:0] got = 'x;
    logic got_ovf = 'x;
    run2 = 1;
    edge2 = 1;
    step();
    for (int c = 0; c < 400; c++) begin
      if (rv2) begin rv_at = c; got = bcd2; got_ovf = ovf2; break; end
      step();
    end
    run2 = 0;
    edge2 = 0;
    vec++; if (rv_at != 310) begin errs++; $display("FAIL sat_latency got %0d want 310", rv_at); end
    vec++; if (got_ovf !== 1'b1) begin errs++; $display("FAIL sat_ovf got %b want 1", got_ovf); end
    vec++; if (got !== SAT_BCD) begin errs++; $display("FAIL sat_bcd got %h want %h", got, SAT_BCD); end
  endtask
  task automatic test_async_reset();
    int n = 0, rv_at = -1;
    logic [11:0] got = 'x;
    run = 1;
    while (!gate_open && n < 40) begin step(); n++; end
    repeat (5) step();
    #3 reset_n = 0;
    #1;
    vec++; if ({gate_open, busy, result_valid, ovf_o, bcd_o} !== 16'h0) begin errs++; $display("FAIL async_reset got %h want 0000", {gate_open, busy, result_valid, ovf_o, bcd_o}); end
    step();
    reset_n = 1;
    step();
    vec++; if ({busy, gate_open} !== 2'b10) begin errs++; $display("FAIL post_reset_arm got %b want 10", {busy, gate_open}); end
    for (int c = 0; c < 40; c++) begin
      if (result_valid) begin rv_at = c; got = bcd_o; break; end
      sig_edge = (c >= 1 && c <= 3);
      step();
    end
    sig_edge = 0;
    vec++; if (rv_at != 30) begin errs++; $display("FAIL post_reset_latency got %0d want 30", rv_at); end
    vec++; if (got !== 12'h003) begin errs++; $display("FAIL post_reset_bcd got %h want 003", got); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_abort();
    test_conv_drop();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/freq_gate_scheduler.md
Name: freq_gate_scheduler

Overview:
Measurement sequencer for the frequency-counter datapath. Opens a fixed gate window and counts edge pulses from the sig edge detector (sig xor sig_d1). At window close it latches the count and converts it to BCD with a sequential double-dabble. It then holds the result for display and re-arms, giving periodic, glitch-free readings to the seg7 digit path.

Parameters:
GATE_CYCLES, 250, gate window length in clk cycles (>=2)
CNT_W, 8, edge-count width; count saturates at 2^CNT_W-1
NDIG, 3, BCD digits in result; 10^NDIG must exceed 2^CNT_W-1
HOLD_CYCLES, 16, cycles result is held in SHOW before re-arm (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
run  input  1  level enable; high = measure continuously
sig_edge  input  1  one-cycle edge pulse from sig edge detector
gate_open  output  1  high exactly during GATE state
busy  output  1  high in every state except IDLE
result_valid  output  1  one-cycle pulse when new bcd_o is presented
ovf_o  output  1  last result saturated; updates with bcd_o
bcd_o  output  4*NDIG  packed BCD result, digit 0 = bits [3:0]

Behaviour:
- Reset (reset_n low, async): state=IDLE, bcd_o=0, ovf_o=0, result_valid=0, gate_open=0, busy=0, all counters 0. Takes effect without a clock edge; release is sampled on the next edge.
- IDLE: run=1 -> ARM next cycle; otherwise stay.
- ARM (1 cycle): clear edge counter, gate counter, sat flag -> GATE.
- GATE (exactly GATE_CYCLES cycles): each cycle with sig_edge=1 increments the edge counter. An edge in the last GATE cycle counts. At 2^CNT_W-1 the counter holds and the sat flag sets. gate_cnt==GATE_CYCLES-1 -> LATCH.
- LATCH (1 cycle): copy count into conversion shift register, clear BCD accumulator -> CONV. sig_edge is ignored in LATCH, CONV and SHOW.
- CONV (exactly CNT_W cycles): one double-dabble shift per cycle (add 3 to any digit >=5, then shift) -> SHOW.
- SHOW: on entry cycle, bcd_o and ovf_o load and result_valid=1 for that cycle only. Stay HOLD_CYCLES cycles total, then run=1 -> ARM, run=0 -> IDLE.
- Latency: ARM at cycle 0 -> result_valid at cycle GATE_CYCLES+CNT_W+2. Period with run held = GATE_CYCLES+CNT_W+HOLD_CYCLES+2.
- run low during ARM or GATE: abort. Next state IDLE, count discarded, bcd_o/ovf_o keep previous values, no result_valid.
- run low during LATCH, CONV or SHOW: sequence completes, result_valid pulses, then IDLE.
- bcd_o and ovf_o change only on the SHOW entry cycle or on reset.

Optional Feature:
Macro FREQ_GATE_OVF_BLANK_EN.
- Defined: a saturated result loads 4'hF into every bcd_o digit (seg7 blank/error code) and sets ovf_o=1.
- Undefined: a saturated result loads the BCD of 2^CNT_W-1 and sets ovf_o=1.
- CONV timing is identical in both builds.

Test Plan:
1. GATE_CYCLES=20, CNT_W=8, HOLD_CYCLES=4. reset_n pulse, then run=1 with sig_edge every 4th GATE cycle -> result_valid 30 cycles after ARM, bcd_o=12'h005, ovf_o=0, gate_open high for exactly 20 cycles.
2. GATE_CYCLES=300, sig_edge held 1 -> ovf_o=1. bcd_o=12'h255 (macro undefined) or 12'hFFF (FREQ_GATE_OVF_BLANK_EN defined).
3. Prior result 12'h005. run dropped in GATE cycle 10 -> IDLE next cycle, busy=0, no result_valid, bcd_o stays 12'h005.
4. run dropped during CONV -> result_valid still pulses once with correct value, SHOW lasts 4 cycles, then IDLE.
5. run held, sig_edge=1 only during LATCH/CONV/SHOW/ARM cycles -> every result bcd_o=12'h000, results spaced 34 cycles apart.
6. reset_n driven low mid-GATE between clock edges -> all outputs 0 immediately. After release with run=1 -> ARM on the first edge, normal measurement follows.
